memory_responder: RTL and testbench

- Word-addressed data memory that serves as the responder end of the CPU memory-register path.
- The memory register drives an address, data and a request; this block accepts one request at a time, performs the read or write, and returns a response after a programmable wait.
- Sits between the CPU memory registers and the datapath result bus.

---
 rtl/memory_responder_if.sv | 31 +++
 rtl/memory_responder.sv | 98 +++++++++
 tb/tb_memory_responder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/memory_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_responder_if
// Brief    : Request/response bundle between CPU memory registers and memory.
// Revision : 1.0
// ============================================================================
interface memory_responder_if #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 16
);
    logic                 reqValid;
    logic                 reqReady;
    logic                 reqWrite;
    logic [BITS_ADDR-1:0] reqAddr;
    logic [BITS_DATA-1:0] reqData;
    logic                 respValid;
    logic                 respReady;
    logic [BITS_DATA-1:0] respData;
    logic                 respError;

    modport master (
        output reqValid, reqWrite, reqAddr, reqData, respReady,
        input  reqReady, respValid, respData, respError
    );

    modport slave (
        input  reqValid, reqWrite, reqAddr, reqData, respReady,
        output reqReady, respValid, respData, respError
    );
endinterface
`default_nettype wire

// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : memory_responder
// Brief    : Word-addressed data memory answering one request at a time.
// Revision : 1.0
// ============================================================================
module memory_responder #(
    parameter int BITS_DATA   = 32,
    parameter int BITS_ADDR   = 16,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    memory_responder_if.slave  bus
);
    localparam int c_DEPTH = 1 << DEPTH_LOG2;
    localparam int c_CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT =
        c_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [BITS_DATA-1:0]  r_resp_data;
    logic                  r_resp_err;
    logic [BITS_DATA-1:0]  r_mem [0:c_DEPTH-1];

    logic                  w_in_range;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_accept;

    // Any set bit above the implemented index range makes the address invalid.
    generate
        if (BITS_ADDR > DEPTH_LOG2) begin : g_range_check
            assign w_in_range = ~|bus.reqAddr[BITS_ADDR-1:DEPTH_LOG2];
            assign w_idx      = bus.reqAddr[DEPTH_LOG2-1:0];
        end else begin : g_all_in_range
            assign w_in_range = 1'b1;
            assign w_idx      = DEPTH_LOG2'(bus.reqAddr);
        end
    endgenerate

    assign w_accept = reset_n && (r_state == c_IDLE) && bus.reqValid;

    assign bus.reqReady  = (r_state == c_IDLE);
    assign bus.respValid = (r_state == c_RESP);
    assign bus.respData  = r_resp_data;
    assign bus.respError = r_resp_err;

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (w_accept && bus.reqWrite && w_in_range) begin
            r_mem[w_idx] <= bus.reqData;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.reqValid) begin
                        r_resp_data <= (w_in_range && !bus.reqWrite) ? r_mem[w_idx] : '0;
                        r_resp_err  <= !w_in_range;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= c_RESP;
                        end else begin
                            r_state <= c_WAIT;
                            r_cnt   <= c_CNT_INIT;
                        end
                    end
                end
                c_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_RESP: begin
                    if (bus.respReady) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_memory_responder
// Brief    : Scoreboard bench for memory_responder with 2 and 0 wait states.
// Revision : 1.0
// ============================================================================
module tb_memory_responder;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   tests   = 0;
    int   fails   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_responder_if #(.BITS_DATA(32), .BITS_ADDR(16)) if2 ();
    memory_responder_if #(.BITS_DATA(32), .BITS_ADDR(16)) if0 ();

    memory_responder #(.BITS_DATA(32), .BITS_ADDR(16), .DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(if2)
    );
    memory_responder #(.BITS_DATA(32), .BITS_ADDR(16), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];
    exp_t e2, e0;
    logic pv2 = 1'b0;
    logic pv0 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitors pop the expected entry on the first cycle of each response.
    always @(negedge clk) begin
        if (if2.respValid === 1'b1 && pv2 !== 1'b1) begin
            if (q2.size() == 0) begin
                tests++; fails++;
                $display("FAIL resp2_unexpected: got response 0x%08h expected none", if2.respData);
            end else begin
                e2 = q2.pop_front();
                chk("resp2_data", if2.respData, e2.data);
                chk("resp2_err", {31'b0, if2.respError}, {31'b0, e2.err});
                chk("resp2_latency", cyc, e2.due);
            end
        end
        pv2 = if2.respValid;
    end

    always @(negedge clk) begin
        if (if0.respValid === 1'b1 && pv0 !== 1'b1) begin
            if (q0.size() == 0) begin
                tests++; fails++;
                $display("FAIL resp0_unexpected: got response 0x%08h expected none", if0.respData);
            end else begin
                e0 = q0.pop_front();
                chk("resp0_data", if0.respData, e0.data);
                chk("resp0_err", {31'b0, if0.respError}, {31'b0, e0.err});
                chk("resp0_latency", cyc, e0.due);
            end
        end
        pv0 = if0.respValid;
    end

    task automatic req(input int which, input logic wr, input logic [15:0] addr,
                       input logic [31:0] wdata, input logic [31:0] edata,
                       input logic eerr, output int acc);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((which == 2) ? if2.reqReady : if0.reqReady) !== 1'b1 && n < 50);
        if (n >= 50) begin
            tests++; fails++;
            $display("FAIL req_ready_timeout: got reqReady=0 expected 1 within 50 cycles");
        end
        acc    = cyc + 1;
        e.data = edata;
        e.err  = eerr;
        e.due  = acc + ((which == 2) ? 2 : 0);
        if (which == 2) begin
            if2.reqValid = 1'b1; if2.reqWrite = wr; if2.reqAddr = addr; if2.reqData = wdata;
            q2.push_back(e);
        end else begin
            if0.reqValid = 1'b1; if0.reqWrite = wr; if0.reqAddr = addr; if0.reqData = wdata;
            q0.push_back(e);
        end
        @(posedge clk);
        #1;
        if2.reqValid = 1'b0;
        if0.reqValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q2.size() != 0 || q0.size() != 0 || if2.respValid !== 1'b0 || if0.respValid !== 1'b0)
               && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_q2_empty", q2.size(), 0);
        chk("drain_q0_empty", q0.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        int a1, a2, n;
        if2.reqValid = 1'b0; if2.reqWrite = 1'b0; if2.reqAddr = '0; if2.reqData = '0;
        if2.respReady = 1'b1;
        if0.reqValid = 1'b0; if0.reqWrite = 1'b0; if0.reqAddr = '0; if0.reqData = '0;
        if0.respReady = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_reqReady", {31'b0, if2.reqReady}, 32'd1);
        chk("reset_respValid", {31'b0, if2.respValid}, 32'd0);
        chk("reset_respData", if2.respData, 32'd0);
        chk("reset_respError", {31'b0, if2.respError}, 32'd0);
        chk("reset_reqReady0", {31'b0, if0.reqReady}, 32'd1);
        reset_n = 1'b1;

        // Write then read with two wait states; accepts are four cycles apart.
        req(2, 1'b1, 16'h0005, 32'hDEADBEEF, 32'h0, 1'b0, a1);
        req(2, 1'b0, 16'h0005, 32'h0, 32'hDEADBEEF, 1'b0, a2);
        chk("b2b_spacing_w2", a2 - a1, 32'd4);
        drain();

        // Out-of-range read and write must not alias onto word 0.
        req(2, 1'b1, 16'h0000, 32'h12345678, 32'h0, 1'b0, a1);
        req(2, 1'b0, 16'h0100, 32'h0, 32'h0, 1'b1, a1);
        req(2, 1'b1, 16'h0100, 32'h00000001, 32'h0, 1'b1, a1);
        req(2, 1'b0, 16'hFFFF, 32'h0, 32'h0, 1'b1, a1);
        req(2, 1'b0, 16'h0000, 32'h0, 32'h12345678, 1'b0, a1);
        drain();

        // Response held off while new requests are offered.
        if2.respReady = 1'b0;
        req(2, 1'b0, 16'h0005, 32'h0, 32'hDEADBEEF, 1'b0, a1);
        n = 0;
        while (if2.respValid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("hold_reached_resp", {31'b0, if2.respValid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if2.reqValid = ((i % 2) == 0);
            if2.reqWrite = ((i % 3) == 0);
            if2.reqAddr  = 16'h0020 + 16'(i);
            if2.reqData  = 32'(i);
            @(negedge clk);
            chk("hold_respValid", {31'b0, if2.respValid}, 32'd1);
            chk("hold_respData", if2.respData, 32'hDEADBEEF);
            chk("hold_reqReady", {31'b0, if2.reqReady}, 32'd0);
        end
        if2.reqValid  = 1'b0;
        if2.respReady = 1'b1;
        @(posedge clk); #1;
        chk("release_respValid", {31'b0, if2.respValid}, 32'd0);
        chk("release_reqReady", {31'b0, if2.reqReady}, 32'd1);
        drain();

        // Zero-wait instance: response the cycle after accept, accepts every 2 cycles.
        req(0, 1'b1, 16'h0003, 32'h0000ABCD, 32'h0, 1'b0, a1);
        req(0, 1'b0, 16'h0003, 32'h0, 32'h0000ABCD, 1'b0, a2);
        chk("b2b_spacing_w0", a2 - a1, 32'd2);
        drain();

        // Asynchronous reset in WAIT, then in RESP; memory must survive.
        req(2, 1'b1, 16'h0010, 32'hCAFEF00D, 32'h0, 1'b0, a1);
        drain();
        req(2, 1'b0, 16'h0010, 32'h0, 32'hCAFEF00D, 1'b0, a1);
        #1;
        chk("wait_pre_reqReady", {31'b0, if2.reqReady}, 32'd0);
        reset_n = 1'b0;
        #1;
        q2.delete();
        chk("rst_wait_respValid", {31'b0, if2.respValid}, 32'd0);
        chk("rst_wait_reqReady", {31'b0, if2.reqReady}, 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        if2.respReady = 1'b0;
        req(2, 1'b0, 16'h0005, 32'h0, 32'hDEADBEEF, 1'b0, a1);
        n = 0;
        while (if2.respValid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("rst_resp_respValid", {31'b0, if2.respValid}, 32'd0);
        chk("rst_resp_reqReady", {31'b0, if2.reqReady}, 32'd1);
        chk("rst_resp_respData", if2.respData, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        if2.respReady = 1'b1;
        req(2, 1'b0, 16'h0010, 32'h0, 32'hCAFEF00D, 1'b0, a1);
        drain();

        // Top-of-range boundary words.
        req(2, 1'b1, 16'h00FF, 32'hFFFFFFFF, 32'h0, 1'b0, a1);
        req(2, 1'b1, 16'h00FE, 32'h00000001, 32'h0, 1'b0, a1);
        req(2, 1'b0, 16'h00FF, 32'h0, 32'hFFFFFFFF, 1'b0, a1);
        req(2, 1'b0, 16'h00FE, 32'h0, 32'h00000001, 1'b0, a1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
